hilo_md_unit: RTL

- E-stage multiply/divide unit and owner of the architectural HI/LO registers.
- Producer end of the HI/LO forwarding path: its hi/lo outputs are piped down the pipeline as HI_M/HI_W and LO_M/LO_W, and the forwarding muxes select them for mfhi/mflo.
- Executes mult/multu/div/divu with fixed multi-cycle latency and mthi/mtlo in one cycle.
- Exposes busy/stall status so the hazard unit holds D-stage mfhi/mflo/md instructions.

---
 rtl/hilo_md_unit_pkg.sv | 27 ++
 rtl/hilo_md_unit_md_datapath.sv | 56 +++++
 rtl/hilo_md_unit.sv | 111 +++++++++++
 3 files changed

// File: rtl/hilo_md_unit_pkg.sv
// Shared constants for the HI/LO multiply/divide unit: operation codes used by the
// decoder to generate md_op, and the controller state encoding.
package hilo_md_unit_pkg;

    localparam logic [2:0] MD_NONE  = 3'd0;
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    typedef enum logic {
        StIdle = 1'b0,
        StRun  = 1'b1
    } md_state_e;

    // Multi-cycle ops: the ones that occupy the unit and raise busy.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

endpackage

// File: rtl/hilo_md_unit_md_datapath.sv
// Combinational multiply/divide datapath: maps the latched op and operands to the
// 64-bit {hi, lo} result and flags division by zero.
module hilo_md_unit_md_datapath
    import hilo_md_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        div_by_zero
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] b_safe;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] mag_q;
    logic [31:0] mag_r;
    logic [31:0] quo_s;
    logic [31:0] rem_s;
    logic [31:0] quo_u;
    logic [31:0] rem_u;

    // Low 64 bits of a sign-extended product equal the signed 64-bit product.
    assign prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u = {32'd0, a} * {32'd0, b};

    // Substitute 1 for a zero divisor so no divide-by-zero is ever evaluated;
    // the result is discarded in that case anyway.
    assign b_safe = (b == 32'd0) ? 32'd1 : b;

    // Signed divide through magnitudes so 0x80000000 / -1 wraps cleanly.
    assign mag_a = a[31] ? (32'd0 - a) : a;
    assign mag_b = b_safe[31] ? (32'd0 - b_safe) : b_safe;
    assign mag_q = mag_a / mag_b;
    assign mag_r = mag_a % mag_b;
    assign quo_s = (a[31] ^ b_safe[31]) ? (32'd0 - mag_q) : mag_q;
    assign rem_s = a[31] ? (32'd0 - mag_r) : mag_r;

    assign quo_u = a / b_safe;
    assign rem_u = a % b_safe;

    always_comb begin
        result      = 64'd0;
        div_by_zero = is_div_op(op) && (b == 32'd0);
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV:   result = {rem_s, quo_s};
            MD_DIVU:  result = {rem_u, quo_u};
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/hilo_md_unit.sv
// E-stage multiply/divide unit owning the architectural HI/LO registers; fixed-latency
// mult/div sequencing, single-cycle mthi/mtlo, and busy/stall status for the hazard unit.
module hilo_md_unit
    import hilo_md_unit_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [2:0]  md_op,
    input  logic        start,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    output logic        busy,
    output logic        md_stall,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int unsigned CNT_W   = $clog2(MAX_LAT) + 1;

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        a_q, a_d;
    logic [31:0]        b_q, b_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [63:0]        dp_result;
    logic               dp_div_by_zero;
    logic               accept;

    hilo_md_unit_md_datapath u_datapath (
        .op          (op_q),
        .a           (a_q),
        .b           (b_q),
        .result      (dp_result),
        .div_by_zero (dp_div_by_zero)
    );

    assign accept = start && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (is_long_op(md_op)) begin
                        op_d    = md_op;
                        a_d     = src_a;
                        b_d     = src_b;
                        cnt_d   = is_div_op(md_op) ? CNT_W'(DIV_LAT - 1) : CNT_W'(MULT_LAT - 1);
                        state_d = StRun;
                    end else if (md_op == MD_MTHI) begin
                        hi_d = src_a;
                    end else if (md_op == MD_MTLO) begin
                        lo_d = src_a;
                    end
                end
            end
            StRun: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                    if (!dp_div_by_zero) begin
                        hi_d = dp_result[63:32];
                        lo_d = dp_result[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy     = (state_q == StRun);
    // Raised in the accept cycle so D-stage logic need not wait a cycle for busy.
    assign md_stall = busy || (start && is_long_op(md_op));
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule
